// File: rtl/mux_scan_sequencer.sv
// Scans a 4:1 mux channel by channel, majority-votes each channel's settled output,
// and publishes the assembled 4-bit snapshot with one-cycle valid/changed pulses.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_SAMPLES   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic [3:0] mask,
  input  logic       mux_in,
  output logic [1:0] sel,
  output logic [3:0] data,
  output logic       valid,
  output logic       changed,
  output logic       busy
);

  localparam int unsigned CW = 8;
  localparam int unsigned SW = 4;
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, NEXT, DONE} state_t;

  state_t        state_q, state_d, entry_state;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          changed_q, changed_d;
  logic          busy_q, busy_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    shadow_q, shadow_d;
  logic [CW-1:0] settle_cnt_q, settle_cnt_d;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic [SW-1:0] ones_q, ones_d, ones_now;
  logic [SW:0]   ones_x2;
  logic          vote, launch;
  logic [2:0]    first_chan, next_chan;

  // Lowest set channel at or above 'first'; bit 2 flags that one was found.
  function automatic logic [2:0] find_chan(input logic [3:0] m, input int first);
    logic [2:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && i >= first) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign entry_state = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
  assign ones_now    = ones_q + SW'(mux_in);
  assign ones_x2     = {ones_now, 1'b0};
  assign vote        = (ones_x2 > (SW+1)'(NUM_SAMPLES));
  assign first_chan  = find_chan(mask, 0);
  assign next_chan   = find_chan(mask_q, int'(sel_q) + 1);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    changed_d    = 1'b0;
    busy_d       = busy_q;
    mask_d       = mask_q;
    shadow_d     = shadow_q;
    settle_cnt_d = settle_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    ones_d       = ones_q;
    launch       = 1'b0;

    case (state_q)
      IDLE: launch = start;
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          state_d      = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + CW'(1);
        end
      end
      SAMPLE: begin
        if (samp_cnt_q == SAMPLE_LAST) begin
          shadow_d[sel_q] = vote;
          samp_cnt_d      = '0;
          ones_d          = '0;
          state_d         = NEXT;
        end else begin
          samp_cnt_d = samp_cnt_q + SW'(1);
          ones_d     = ones_now;
        end
      end
      NEXT: begin
        if (next_chan[2]) begin
          sel_d   = next_chan[1:0];
          state_d = entry_state;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        launch  = continuous;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new scan starts from the last published word (DONE already made shadow == data).
    if (launch) begin
      mask_d       = mask;
      shadow_d     = (state_q == DONE) ? shadow_q : data_q;
      settle_cnt_d = '0;
      if (first_chan[2]) begin
        sel_d   = first_chan[1:0];
        state_d = entry_state;
      end else begin
        state_d = DONE;
      end
    end

    if (state_d == DONE) begin
      data_d    = shadow_d;
      valid_d   = 1'b1;
      changed_d = (shadow_d != data_q);
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      changed_q    <= 1'b0;
      busy_q       <= 1'b0;
      mask_q       <= '0;
      shadow_q     <= '0;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      ones_q       <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      changed_q    <= changed_d;
      busy_q       <= busy_d;
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      ones_q       <= ones_d;
    end
  end

  assign sel     = sel_q;
  assign data    = data_q;
  assign valid   = valid_q;
  assign changed = changed_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a vector table of single scans plus
// hand-written glitch, continuous-mode and mid-scan reset sequences.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, continuous, mux_in;
  logic [3:0] mask;
  logic [1:0] sel;
  logic [3:0] data;
  logic       valid, changed, busy;

  logic [3:0] ch_val;
  logic       glitch_mode, glitch_bit;

  int checks = 0;
  int errors = 0;

  mux_scan_sequencer #(.SETTLE_CYCLES(2), .NUM_SAMPLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .mask(mask), .mux_in(mux_in), .sel(sel), .data(data),
    .valid(valid), .changed(changed), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural 4:1 mux: each channel holds a static level unless a glitch pattern is forced.
  assign mux_in = glitch_mode ? glitch_bit : ch_val[sel];

  typedef struct {
    logic [3:0] mask;
    logic [3:0] chv;
    logic [3:0] exp_data;
    logic       exp_changed;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One single-shot scan started now; checks latency, word, pulses, sel order and busy.
  task automatic run_scan(input logic [3:0] m, input logic [3:0] chv, input logic use_glitch,
                          input logic [2:0] pat, input logic [3:0] exp_data,
                          input logic exp_changed, input int exp_lat);
    int         c;
    logic [2:0] last_sel;
    logic [3:0] vis;
    logic       order_ok, busy_ok;
    c = 0; last_sel = 3'b100; vis = '0; order_ok = 1'b1; busy_ok = 1'b1;
    mask = m; ch_val = chv; glitch_mode = use_glitch; glitch_bit = 1'b0;
    start = 1'b1;
    while (c < 200) begin
      @(posedge clk); #1;
      c++;
      start = 1'b0;
      if (use_glitch && c >= 3 && c <= 5) glitch_bit = pat[c-3];
      if (valid) break;
      if (!busy) busy_ok = 1'b0;
      if ({1'b0, sel} != last_sel) begin
        if (!last_sel[2] && sel <= last_sel[1:0]) order_ok = 1'b0;
        last_sel = {1'b0, sel};
        vis[sel] = 1'b1;
      end
    end
    glitch_mode = 1'b0;
    chk("scan_latency", 32'(c), 32'(exp_lat));
    chk("scan_data", 32'(data), 32'(exp_data));
    chk("scan_changed", 32'(changed), 32'(exp_changed));
    chk("scan_sel_visited", 32'(vis), 32'(m));
    chk("scan_sel_order", 32'(order_ok), 32'd1);
    chk("scan_busy", 32'(busy_ok), 32'd1);
    @(posedge clk); #1;
    chk("valid_one_cycle", 32'({valid, busy}), 32'd0);
  endtask

  initial begin
    int c, nvalid;
    logic busy_ok, stray;

    vecs[0] = '{4'hF,    4'b1101, 4'b1101, 1'b1, 25};
    vecs[1] = '{4'hF,    4'b1101, 4'b1101, 1'b0, 25};
    vecs[2] = '{4'b0010, 4'b0010, 4'b1111, 1'b1, 7};
    vecs[3] = '{4'b0000, 4'b0000, 4'b1111, 1'b0, 1};
    vecs[4] = '{4'hF,    4'b0000, 4'b0000, 1'b1, 25};
    vecs[5] = '{4'b1001, 4'b1111, 4'b1001, 1'b1, 13};

    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; mask = '0;
    ch_val = '0; glitch_mode = 1'b0; glitch_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_changed", 32'(changed), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_scan(vecs[i].mask, vecs[i].chv, 1'b0, 3'b000,
               vecs[i].exp_data, vecs[i].exp_changed, vecs[i].exp_lat);

    // Channel 2 glitches: samples 1,0,0 vote 0; samples 1,1,0 vote 1.
    run_scan(4'b0100, 4'b0000, 1'b1, 3'b001, 4'b1001, 1'b0, 7);
    run_scan(4'b0100, 4'b0000, 1'b1, 3'b011, 4'b1101, 1'b1, 7);

    // Continuous mode: period 25, ignored mid-scan start and mask change.
    continuous = 1'b1; mask = 4'hF; ch_val = 4'b0010; start = 1'b1;
    c = 0; nvalid = 0; busy_ok = 1'b1;
    while (nvalid < 3 && c < 200) begin
      @(posedge clk); #1;
      c++;
      start = (c == 30 || c == 31);
      if (c == 55) mask = 4'b0001;
      if (c == 60) continuous = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (valid) begin
        nvalid++;
        chk("cont_period", 32'(c), 32'(25 * nvalid));
        chk("cont_data", 32'(data), 32'b0010);
        chk("cont_changed", 32'(changed), 32'(nvalid == 1));
      end
    end
    start = 1'b0;
    chk("cont_pulses", 32'(nvalid), 32'd3);
    chk("cont_busy", 32'(busy_ok), 32'd1);
    @(posedge clk); #1;
    chk("cont_exit_idle", 32'({valid, busy}), 32'd0);

    // Reset during channel 2 sampling aborts the scan.
    mask = 4'hF; ch_val = 4'b1101; start = 1'b1; c = 0;
    while (c < 16) begin
      @(posedge clk); #1;
      c++;
      start = 1'b0;
    end
    chk("pre_rst_sel", 32'(sel), 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (valid || busy) stray = 1'b1;
    end
    chk("midrst_no_valid", 32'(stray), 32'd0);
    run_scan(4'hF, 4'b1101, 1'b0, 3'b000, 4'b1101, 1'b1, 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
